// File: rtl/branch_target_predictor_pkg.sv
// Shared types and helpers for the branch target buffer.
package branch_target_predictor_pkg;

    typedef logic [31:0] word_t;

    // Direction counter encodings for the default 2-bit configuration.
    localparam logic [1:0] BTB_CTR_WEAK_T  = 2'b10;
    localparam logic [1:0] BTB_CTR_WEAK_NT = 2'b01;

    // A resolved instruction was mispredicted if the direction was wrong, or
    // both agreed on taken but the carried target differs from the real one.
    function automatic logic btb_mispredict(input logic pred_taken, input word_t pred_target,
                                            input logic taken, input word_t target);
        return (pred_taken != taken) || (taken && pred_taken && (pred_target != target));
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup, MEM-stage update and statistics bundle of the BTB.
interface branch_target_predictor_if import branch_target_predictor_pkg::*; #(
    parameter int STAT_W = 16
);
    word_t             lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    word_t             pred_target;
    logic              upd_en;
    word_t             upd_pc;
    logic              upd_taken;
    word_t             upd_target;
    logic              upd_is_jump;
    logic              upd_pred_taken;
    word_t             upd_pred_target;
    logic              flush_all;
    logic [STAT_W-1:0] stat_updates;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target, flush_all,
        input  pred_hit, pred_taken, pred_target, stat_updates, stat_mispred
    );

    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target, flush_all,
        output pred_hit, pred_taken, pred_target, stat_updates, stat_mispred
    );
endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up-counter used for the BTB statistics; it sticks at all ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count one event per enabled cycle, holding at the maximum value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (en && inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational on the fetch PC; updates come from MEM resolution.
module branch_target_predictor import branch_target_predictor_pkg::*; #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    branch_target_predictor_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    btb_entry_t entries [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    btb_entry_t       l_entry;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    btb_entry_t       u_entry;
    logic             u_hit;
    logic             accepted;
    logic             mispred;
    logic             unused_pc_bits;

    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    assign l_idx          = bus.lookup_pc[IDX_W+1:2];
    assign l_tag          = bus.lookup_pc[31:IDX_W+2];
    assign u_idx          = bus.upd_pc[IDX_W+1:2];
    assign u_tag          = bus.upd_pc[31:IDX_W+2];
    assign unused_pc_bits = ^bus.upd_pc[1:0];

    // Fetch-side prediction from the current (pre-update) entry contents.
    always_comb begin
        l_entry         = entries[l_idx];
        bus.pred_hit    = l_entry.valid && (l_entry.tag == l_tag);
        bus.pred_taken  = bus.pred_hit && l_entry.ctr[CTR_W-1];
        bus.pred_target = bus.pred_taken ? l_entry.target : bus.lookup_pc + 32'd4;
    end

    // Resolve-side hit detection and mispredict classification.
    always_comb begin
        u_entry  = entries[u_idx];
        u_hit    = u_entry.valid && (u_entry.tag == u_tag);
        accepted = bus.upd_en && !bus.flush_all;
        mispred  = btb_mispredict(bus.upd_pred_taken, bus.upd_pred_target,
                                  bus.upd_taken, bus.upd_target);
    end

    // Entry array: flush beats update; a taken miss allocates over any alias.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
            end
        end else if (bus.flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (bus.upd_en) begin
            if (u_hit) begin
                if (bus.upd_is_jump) begin
                    entries[u_idx].ctr    <= CTR_MAX;
                    entries[u_idx].target <= bus.upd_target;
                end else if (bus.upd_taken) begin
                    entries[u_idx].ctr    <= ctr_inc(u_entry.ctr);
                    entries[u_idx].target <= bus.upd_target;
                end else begin
                    entries[u_idx].ctr    <= ctr_dec(u_entry.ctr);
                end
            end else if (bus.upd_taken) begin
                entries[u_idx] <= '{valid:  1'b1,
                                    tag:    u_tag,
                                    target: bus.upd_target,
                                    ctr:    (bus.upd_is_jump ? CTR_MAX : CTR_WEAK_T)};
            end
        end
    end

    sat_counter #(.W(STAT_W)) u_stat_updates (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (accepted),
        .inc  (1'b1),
        .q    (bus.stat_updates)
    );

    sat_counter #(.W(STAT_W)) u_stat_mispred (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (accepted),
        .inc  (mispred),
        .q    (bus.stat_mispred)
    );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for the branch target buffer (ENTRIES=16, CTR_W=2, STAT_W=4).
module tb_branch_target_predictor;
    import branch_target_predictor_pkg::*;

    localparam int ENTRIES  = 16;
    localparam int CTR_W    = 2;
    localparam int STAT_W   = 4;
    localparam int STAT_MAX = 15;
    localparam int CTR_TOP  = 3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

    branch_target_predictor_if #(.STAT_W(STAT_W)) bus();

    branch_target_predictor #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .STAT_W  (STAT_W)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_upd;
    int          m_mis;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return 32'(bus.pred_hit);
            1:       return 32'(bus.pred_taken);
            2:       return bus.pred_target;
            3:       return 32'(bus.stat_updates);
            default: return 32'(bus.stat_mispred);
        endcase
    endfunction

    task automatic push(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.nm  = nm;
        e.sel = sel;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_upd = 0;
        m_mis = 0;
    endtask

    task automatic model_update(input logic ue, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utg, input logic uj, input logic upt,
                                input logic [31:0] uptg, input logic fl);
        int          ui;
        logic [25:0] utag;
        ui   = int'(upc[5:2]);
        utag = upc[31:6];
        if (fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (ue) begin
            if (m_upd < STAT_MAX) m_upd++;
            if ((upt != ut) || (ut && upt && (uptg != utg))) begin
                if (m_mis < STAT_MAX) m_mis++;
            end
            if (m_valid[ui] && (m_tag[ui] == utag)) begin
                if (uj) begin
                    m_ctr[ui] = CTR_TOP;
                    m_tgt[ui] = utg;
                end else if (ut) begin
                    if (m_ctr[ui] < CTR_TOP) m_ctr[ui]++;
                    m_tgt[ui] = utg;
                end else if (m_ctr[ui] > 0) begin
                    m_ctr[ui]--;
                end
            end else if (ut) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = utag;
                m_tgt[ui]   = utg;
                m_ctr[ui]   = uj ? CTR_TOP : 2;
            end
        end
    endtask

    // One clock: drive after the edge, queue model expectations, compare at negedge.
    task automatic cycle(input string nm, input logic [31:0] lpc, input logic ue,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                         input logic uj, input logic upt, input logic [31:0] uptg,
                         input logic fl);
        int          li;
        logic [25:0] lt;
        bit          h;
        bit          tk;
        exp_t        e;
        @(posedge CLK);
        #1;
        bus.lookup_pc       = lpc;
        bus.upd_en          = ue;
        bus.upd_pc          = upc;
        bus.upd_taken       = ut;
        bus.upd_target      = utg;
        bus.upd_is_jump     = uj;
        bus.upd_pred_taken  = upt;
        bus.upd_pred_target = uptg;
        bus.flush_all       = fl;
        li = int'(lpc[5:2]);
        lt = lpc[31:6];
        h  = m_valid[li] && (m_tag[li] == lt);
        tk = h && (m_ctr[li] >= 2);
        push({nm, ".hit"},    0, 32'(h));
        push({nm, ".taken"},  1, 32'(tk));
        push({nm, ".target"}, 2, tk ? m_tgt[li] : lpc + 32'd4);
        push({nm, ".upd"},    3, 32'(m_upd));
        push({nm, ".mis"},    4, 32'(m_mis));
        @(negedge CLK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.nm, observe(e.sel), e.v);
        end
        model_update(ue, upc, ut, utg, uj, upt, uptg, fl);
    endtask

    task automatic look(input string nm, input logic [31:0] lpc);
        cycle(nm, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input string nm, input logic [31:0] lpc, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic uj,
                       input logic upt, input logic [31:0] uptg);
        cycle(nm, lpc, 1'b1, upc, ut, utg, uj, upt, uptg, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic        r_ue, r_ut, r_uj, r_upt, r_fl;
        logic [31:0] r_utg, r_uptg;

        bus.lookup_pc       = 32'h48;
        bus.upd_en          = 1'b0;
        bus.upd_pc          = '0;
        bus.upd_taken       = 1'b0;
        bus.upd_target      = '0;
        bus.upd_is_jump     = 1'b0;
        bus.upd_pred_taken  = 1'b0;
        bus.upd_pred_target = '0;
        bus.flush_all       = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #3 nRST = 1'b1;

        // 1: reset state
        look("t1", 32'h48);
        check("t1.hit_c",    32'(bus.pred_hit),     32'h0);
        check("t1.taken_c",  32'(bus.pred_taken),   32'h0);
        check("t1.target_c", bus.pred_target,       32'h4C);
        check("t1.upd_c",    32'(bus.stat_updates), 32'h0);

        // 2: allocate on taken miss, then weaken with a not-taken update
        upd("t2.alloc", 32'h48, 32'h48, 1'b1, 32'h100, 1'b0, 1'b0, 32'h4C);
        look("t2.look", 32'h48);
        check("t2.hit_c",    32'(bus.pred_hit),     32'h1);
        check("t2.taken_c",  32'(bus.pred_taken),   32'h1);
        check("t2.target_c", bus.pred_target,       32'h100);
        check("t2.mis_c",    32'(bus.stat_mispred), 32'h1);
        upd("t2.nt", 32'h48, 32'h48, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        look("t2.look2", 32'h48);
        check("t2.hit2_c",    32'(bus.pred_hit),   32'h1);
        check("t2.taken2_c",  32'(bus.pred_taken), 32'h0);
        check("t2.target2_c", bus.pred_target,     32'h4C);

        // 3: alias at the same index; same-cycle lookup sees old contents
        upd("t3.alias", 32'h88, 32'h88, 1'b1, 32'h200, 1'b0, 1'b0, 32'h8C);
        check("t3.same_c", 32'(bus.pred_hit), 32'h0);
        look("t3.old", 32'h48);
        check("t3.old_c", 32'(bus.pred_hit), 32'h0);
        look("t3.new", 32'h88);
        check("t3.new_c", bus.pred_target, 32'h200);

        // 4: counter saturation and jump allocation at full strength
        for (int i = 0; i < 4; i++) begin
            upd($sformatf("t4.tk%0d", i), 32'h48, 32'h48, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100);
        end
        upd("t4.nt", 32'h48, 32'h48, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        look("t4.look", 32'h48);
        check("t4.sat_c", 32'(bus.pred_taken), 32'h1);
        upd("t4.jmp", 32'hC0, 32'hC0, 1'b1, 32'h400, 1'b1, 1'b0, 32'hC4);
        look("t4.jlook", 32'hC0);
        check("t4.jtarget_c", bus.pred_target, 32'h400);
        upd("t4.jnt", 32'hC0, 32'hC0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
        look("t4.jlook2", 32'hC0);
        check("t4.jstrong_c", 32'(bus.pred_taken), 32'h1);

        // 5: flush wins over a same-cycle update, then asynchronous reset
        cycle("t5.flush", 32'h48, 1'b1, 32'h48, 1'b1, 32'h300, 1'b0, 1'b0, 32'h4C, 1'b1);
        look("t5.l48", 32'h48);
        check("t5.upd_c", 32'(bus.stat_updates), 32'd10);
        look("t5.l88", 32'h88);
        look("t5.lC0", 32'hC0);
        upd("t5.realloc", 32'h88, 32'h88, 1'b1, 32'h200, 1'b0, 1'b0, 32'h8C);
        look("t5.pre", 32'h88);
        #2;
        bus.upd_en    = 1'b0;
        bus.flush_all = 1'b0;
        nRST          = 1'b0;
        #1;
        check("t5.rst_hit",    32'(bus.pred_hit),     32'h0);
        check("t5.rst_taken",  32'(bus.pred_taken),   32'h0);
        check("t5.rst_target", bus.pred_target,       32'h8C);
        check("t5.rst_upd",    32'(bus.stat_updates), 32'h0);
        check("t5.rst_mis",    32'(bus.stat_mispred), 32'h0);
        model_reset();
        @(posedge CLK);
        #3 nRST = 1'b1;
        look("t5.post", 32'h88);

        // 6: statistics saturate without wrapping
        for (int i = 0; i < 20; i++) begin
            upd($sformatf("t6.m%0d", i), 32'h10, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 32'h14);
        end
        look("t6.look", 32'h10);
        check("t6.upd_c", 32'(bus.stat_updates), 32'd15);
        check("t6.mis_c", 32'(bus.stat_mispred), 32'd15);

        // Random traffic over a few aliasing indices against the model
        for (int i = 0; i < 80; i++) begin
            p      = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
            r_ue   = ($urandom_range(0, 3) != 0);
            r_uj   = ($urandom_range(0, 3) == 0);
            r_ut   = r_uj | 1'($urandom_range(0, 1));
            r_upt  = 1'($urandom_range(0, 1));
            r_utg  = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            r_uptg = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            r_fl   = ($urandom_range(0, 15) == 0);
            cycle($sformatf("rnd%0d", i),
                  (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2),
                  r_ue, p, r_ut, r_utg, r_uj, r_upt, r_uptg, r_fl);
        end
        look("end", 32'h48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Parametrised branch target buffer (BTB) with per-entry saturating direction counters. It lets the pipelined datapath predict branches and jumps in IF instead of always fetching PC+4 and flushing when the branch resolves in MEM. Lookup is combinational on the fetch PC. Update is synchronous, driven by the MEM-stage resolution of each branch or jump. The block also keeps saturating update and mispredict statistics.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of 2, ≥2
CTR_W, 2, direction counter width; ≥1
STAT_W, 16, width of the statistics counters
(localparams) IDX_W = log2(ENTRIES); TAG_W = 30 − IDX_W

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
lookup_pc  in  32  fetch PC (IF stage)
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  32  predicted next PC
upd_en  in  1  resolved branch/jump present this cycle
upd_pc  in  32  PC of the resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  32  actual target (branch or jump address)
upd_is_jump  in  1  unconditional J/JAL/JR
upd_pred_taken  in  1  prediction carried down the pipe with this instruction
upd_pred_target  in  32  predicted target carried down the pipe
flush_all  in  1  invalidate every entry
stat_updates  out  STAT_W  count of accepted updates
stat_mispred  out  STAT_W  count of mispredicted updates

Behaviour:
- Addressing: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry contents: valid, tag, target[31:0], ctr[CTR_W−1:0].
- Lookup (combinational, zero latency):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & ctr MSB.
  - pred_target = pred_taken ? entry target : lookup_pc + 4.
- Update (registered at posedge when upd_en=1 and flush_all=0):
  - Hit, upd_is_jump=1: ctr := all ones; target := upd_target.
  - Hit, branch: ctr saturating +1 if taken, −1 if not taken. Target is rewritten only when taken.
  - Miss, upd_taken=1: allocate (overwrite any alias). valid=1, tag, target := upd_target; ctr := all ones for a jump, else 2^(CTR_W−1) (weakly taken).
  - Miss, upd_taken=0: no allocation.
- Mispredict = (upd_pred_taken ≠ upd_taken) | (upd_taken & upd_pred_taken & upd_pred_target ≠ upd_target).
- Statistics:
  - stat_updates +1 per accepted update.
  - stat_mispred +1 per accepted mispredicted update.
  - Both saturate at 2^STAT_W − 1; no wrap.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents (no bypass). The new value is visible the next cycle.
- flush_all: clears every valid bit in one cycle. ctr, target and the statistics are unchanged. If asserted in the same cycle as upd_en, flush wins and the update, including its statistics, is dropped.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits = 0; ctr = 2^(CTR_W−1) − 1 (weakly not taken); targets = 0; stat counters = 0.
  - Consequently pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
- CTR_W=1 degenerates to a last-outcome predictor; the same rules apply.
- The block never stalls. Upstream must present at most one update per cycle.

Decomposition:
- Shared package (cpu_types_pkg extension):
  - btb_entry_t struct (valid, tag, target, ctr), parameterised through localparams in the module.
  - BTB_CTR_WEAK_T / BTB_CTR_WEAK_NT constants for CTR_W=2.
  - word_t reused for all PCs and targets.
- One sub-module: sat_counter (parameter W; inc, en, q with saturation), instantiated twice for the statistics.
- The entry array stays inline as an always_ff over a btb_entry_t array.

Test Plan:
All scenarios use ENTRIES=16, CTR_W=2, STAT_W=4.
1. Reset, then lookup_pc=0x48 → pred_hit=0, pred_taken=0, pred_target=0x4C; stat_updates=0.
2. Update pc=0x48, taken, target=0x100, is_jump=0, pred_taken=0 → next cycle lookup 0x48: hit=1, taken=1, target=0x100; stat_mispred=1. Then one not-taken update → hit=1, taken=0, target=0x4C.
3. Alias: update pc=0x88 (index 2, tag 2), taken, target=0x200 → lookup 0x48 hit=0; lookup 0x88 target=0x200. Same-cycle lookup of 0x88 during that update → hit=0.
4. Saturation: 4 taken updates at 0x48, then 1 not-taken → still pred_taken=1. Jump update at a fresh pc 0xC0 → ctr=3 immediately.
5. flush_all together with a taken update at 0x48 → every lookup hit=0; stat_updates unchanged. Assert nRST low mid-sequence → all outputs return to reset values asynchronously.
6. 20 consecutive mispredicted updates → stat_updates=15 and stat_mispred=15 (saturated, no wrap).
